// File: rtl/game_round_ctrl.sv
// -----------------------------------------------------------------------------
// game_round_ctrl
//
// Round sequencer for a two-player game. It waits for a start press, holds the
// point generator in reset for a short clear pulse, runs a timed round while
// watching both scores, then latches the winner and shows the final score
// until the next start press.
//
// Parameters
//   TICKS_PER_SEC : clk cycles per game second
//   ROUND_SEC     : round length in seconds (1..255)
//   WIN_POINTS    : score that ends the round early (1..31)
//   CLEAR_CYCLES  : gen_rst pulse length in cycles (>=1)
//
// Ports
//   clk          in   system clock, single domain
//   rst          in   synchronous active-high reset
//   start        in   start button level (debounced, synchronous)
//   points_1/2   in   5-bit scores from the point generator
//   gen_rst      out  reset to the point generator and score counters
//   game_active  out  high only while a round is being played
//   time_left    out  seconds remaining in the round
//   winner       out  00 none, 01 player 1, 10 player 2, 11 draw
//   state        out  00 IDLE, 01 CLEAR, 10 PLAY, 11 OVER (also a debug view)
//
// There is no valid/ready handshake on this block: start is a level and only
// its rising edge (start high now, low the cycle before) is acted upon, and
// only in IDLE or OVER. Every output comes straight from a flop.
// -----------------------------------------------------------------------------
module game_round_ctrl #(
  parameter int TICKS_PER_SEC = 65_000_000,
  parameter int ROUND_SEC     = 60,
  parameter int WIN_POINTS    = 20,
  parameter int CLEAR_CYCLES  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [4:0] points_1,
  input  logic [4:0] points_2,
  output logic       gen_rst,
  output logic       game_active,
  output logic [7:0] time_left,
  output logic [1:0] winner,
  output logic [1:0] state
);

  // Counter widths follow the parameter; a width of at least one bit keeps
  // the degenerate TICKS_PER_SEC=1 / CLEAR_CYCLES=1 cases legal.
  localparam int PRESC_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int CLR_W   = (CLEAR_CYCLES  > 1) ? $clog2(CLEAR_CYCLES)  : 1;

  localparam logic [PRESC_W-1:0] PRESC_MAX  = PRESC_W'(TICKS_PER_SEC - 1);
  // The clear counter counts down to zero, so it is loaded with N-1 to give
  // exactly CLEAR_CYCLES cycles in CLEAR.
  localparam logic [CLR_W-1:0]   CLR_LOAD   = CLR_W'(CLEAR_CYCLES - 1);
  localparam logic [7:0]         ROUND_LOAD = 8'(ROUND_SEC);
  localparam logic [4:0]         WIN_THR    = 5'(WIN_POINTS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_CLEAR = 2'b01,
    S_PLAY  = 2'b10,
    S_OVER  = 2'b11
  } state_t;

  state_t             r_state;
  logic               r_start_q;
  logic               r_gen_rst;
  logic               r_game_active;
  logic [7:0]         r_time_left;
  logic [1:0]         r_winner;
  logic [PRESC_W-1:0] r_presc;
  logic [CLR_W-1:0]   r_clr_cnt;

  logic               w_start_edge;
  logic               w_tick;
  logic               w_score_end;
  logic               w_time_end;
  logic [1:0]         w_winner_next;

  assign w_start_edge = start & ~r_start_q;
  assign w_tick       = (r_presc == PRESC_MAX);
  assign w_score_end  = (points_1 >= WIN_THR) || (points_2 >= WIN_THR);
  // The round ends on the tick that takes time_left from 1 to 0.
  assign w_time_end   = w_tick && (r_time_left == 8'd1);

  // Winner is decided purely on the score comparison, whichever way the
  // round ended (score, time, or both on the same cycle).
  always_comb begin
    w_winner_next = 2'b11;
    if (points_1 > points_2) begin
      w_winner_next = 2'b01;
    end else if (points_2 > points_1) begin
      w_winner_next = 2'b10;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      // Tracking the live start level during reset means a button held
      // through reset release is seen as already high, so it cannot create
      // an edge; with start low this is the required start_q = 0.
      r_start_q     <= start;
      r_gen_rst     <= 1'b1;
      r_game_active <= 1'b0;
      r_time_left   <= ROUND_LOAD;
      r_winner      <= 2'b00;
      r_presc       <= '0;
      r_clr_cnt     <= '0;
    end else begin
      r_start_q <= start;

      case (r_state)
        S_IDLE: begin
          r_gen_rst     <= 1'b1;
          r_game_active <= 1'b0;
          r_time_left   <= ROUND_LOAD;
          r_winner      <= 2'b00;
          r_presc       <= '0;
          if (w_start_edge) begin
            r_state   <= S_CLEAR;
            r_clr_cnt <= CLR_LOAD;
          end
        end

        S_CLEAR: begin
          if (r_clr_cnt == '0) begin
            r_state       <= S_PLAY;
            r_gen_rst     <= 1'b0;
            r_game_active <= 1'b1;
            r_presc       <= '0;
          end else begin
            r_clr_cnt <= r_clr_cnt - 1'b1;
          end
        end

        S_PLAY: begin
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
          if (w_tick && (r_time_left != 8'd0)) begin
            r_time_left <= r_time_left - 8'd1;
          end
          if (w_score_end || w_time_end) begin
            r_state       <= S_OVER;
            r_game_active <= 1'b0;
            r_winner      <= w_winner_next;
          end
        end

        S_OVER: begin
          // Generator stays out of reset so the final scores remain visible.
          r_gen_rst     <= 1'b0;
          r_game_active <= 1'b0;
          if (w_start_edge) begin
            r_state     <= S_CLEAR;
            r_clr_cnt   <= CLR_LOAD;
            r_winner    <= 2'b00;
            r_time_left <= ROUND_LOAD;
            r_gen_rst   <= 1'b1;
          end
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign gen_rst     = r_gen_rst;
  assign game_active = r_game_active;
  assign time_left   = r_time_left;
  assign winner      = r_winner;
  assign state       = r_state;

endmodule

// File: tb/tb_game_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_game_round_ctrl
//
// Directed bench for game_round_ctrl with TICKS_PER_SEC=10, ROUND_SEC=3,
// WIN_POINTS=5, CLEAR_CYCLES=4. Inputs change and outputs are sampled 1 time
// unit after each rising clock edge.
// -----------------------------------------------------------------------------
module tb_game_round_ctrl;

  localparam int TPS = 10;
  localparam int RS  = 3;
  localparam int WP  = 5;
  localparam int CC  = 4;

  // ---------------------------------------------------------------- clock/reset
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [4:0] points_1;
  logic [4:0] points_2;
  logic       gen_rst;
  logic       game_active;
  logic [7:0] time_left;
  logic [1:0] winner;
  logic [1:0] state;

  always #5 clk = ~clk;

  game_round_ctrl #(
    .TICKS_PER_SEC(TPS),
    .ROUND_SEC    (RS),
    .WIN_POINTS   (WP),
    .CLEAR_CYCLES (CC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .points_1   (points_1),
    .points_2   (points_2),
    .gen_rst    (gen_rst),
    .game_active(game_active),
    .time_left  (time_left),
    .winner     (winner),
    .state      (state)
  );

  // ---------------------------------------------------------------- scoreboard
  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic wait_clk();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) wait_clk();
  endtask

  // Pulse start once from a low level and wait (bounded) for PLAY.
  task automatic to_play(input string tag);
    start = 1'b0;
    wait_clk();
    start = 1'b1;
    wait_clk();
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (state == 2'b10) break;
      wait_clk();
    end
    check_eq(tag, state, 2'b10);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int         n_clr;
    int         n_gen;
    int         n_entry;
    int         gen_bad;
    logic [1:0] prev_state;

    rst      = 1'b1;
    start    = 1'b1;
    points_1 = 5'd0;
    points_2 = 5'd0;
    wait_n(2);

    // Reset values, with start held high through reset.
    check_eq("rst_state",  state,       2'b00);
    check_eq("rst_genrst", gen_rst,     1'b1);
    check_eq("rst_active", game_active, 1'b0);
    check_eq("rst_time",   time_left,   8'd3);
    check_eq("rst_winner", winner,      2'b00);

    rst = 1'b0;
    wait_n(3);
    check_eq("held_start_no_edge", state, 2'b00);

    // One start pulse: CLEAR for exactly CC cycles with gen_rst high.
    points_1 = 5'd2;
    points_2 = 5'd2;
    start = 1'b0;
    wait_clk();
    start = 1'b1;
    wait_clk();
    start = 1'b0;
    check_eq("clear_entry",  state,     2'b01);
    check_eq("clear_winner", winner,    2'b00);
    n_clr   = 1;
    gen_bad = (gen_rst != 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      wait_clk();
      if (state == 2'b01) begin
        n_clr++;
        if (gen_rst != 1'b1) gen_bad++;
      end else begin
        break;
      end
    end
    check_eq("clear_len",     n_clr,       CC);
    check_eq("clear_genrst",  gen_bad,     0);
    check_eq("play_state",    state,       2'b10);
    check_eq("play_active",   game_active, 1'b1);
    check_eq("play_time",     time_left,   8'd3);
    check_eq("play_genrst",   gen_rst,     1'b0);

    // Draw at 2:2 running to time-out; one tick every TPS cycles.
    exp_q.push_back(8'd2);
    exp_q.push_back(8'd1);
    exp_q.push_back(8'd0);
    wait_n(TPS - 1);
    check_eq("pre_tick_time", time_left, 8'd3);
    wait_clk();
    check_eq("tick1_time", time_left, exp_q.pop_front());
    check_eq("tick1_state", state, 2'b10);
    wait_n(TPS - 1);
    check_eq("pre_tick2_time", time_left, 8'd2);
    wait_clk();
    check_eq("tick2_time", time_left, exp_q.pop_front());
    wait_n(TPS);
    check_eq("tick3_time",   time_left,   exp_q.pop_front());
    check_eq("timeout_state", state,      2'b11);
    check_eq("timeout_winner", winner,    2'b11);
    check_eq("timeout_active", game_active, 1'b0);
    check_eq("timeout_genrst", gen_rst,   1'b0);
    check_eq("queue_empty",   exp_q.size(), 0);
    wait_n(15);
    check_eq("over_hold_time",  time_left, 8'd0);
    check_eq("over_hold_state", state,     2'b11);

    // Start held high in OVER: exactly one new round, no retrigger.
    start      = 1'b1;
    n_entry    = 0;
    n_gen      = 0;
    prev_state = state;
    for (int i = 0; i < 50; i++) begin
      wait_clk();
      if (i == 0) check_eq("restart_winner_clr", winner, 2'b00);
      if (state == 2'b01 && prev_state != 2'b01) n_entry++;
      if (gen_rst) n_gen++;
      prev_state = state;
    end
    check_eq("held_clear_entries", n_entry, 1);
    check_eq("held_genrst_cycles", n_gen,   CC);
    check_eq("held_end_state",     state,   2'b11);
    start = 1'b0;

    // Score end: player 1 reaches WIN_POINTS while player 2 has 3.
    points_1 = 5'd0;
    points_2 = 5'd3;
    to_play("score_to_play");
    wait_n(3);
    points_1 = 5'd5;
    wait_clk();
    check_eq("score_state",  state,       2'b11);
    check_eq("score_winner", winner,      2'b01);
    check_eq("score_active", game_active, 1'b0);
    check_eq("score_time",   time_left,   8'd3);
    wait_n(20);
    check_eq("score_time_frozen", time_left, 8'd3);
    check_eq("score_winner_hold", winner,    2'b01);

    // Reset in the middle of PLAY.
    points_1 = 5'd0;
    points_2 = 5'd0;
    to_play("rst_to_play");
    wait_n(TPS);
    check_eq("midplay_time", time_left, 8'd2);
    rst = 1'b1;
    wait_clk();
    rst = 1'b0;
    check_eq("midplay_rst_state",  state,     2'b00);
    check_eq("midplay_rst_genrst", gen_rst,   1'b1);
    check_eq("midplay_rst_time",   time_left, 8'd3);
    check_eq("midplay_rst_winner", winner,    2'b00);
    check_eq("midplay_rst_active", game_active, 1'b0);

    // Reset in the middle of CLEAR.
    start = 1'b1;
    wait_n(2);
    start = 1'b0;
    check_eq("midclear_state", state, 2'b01);
    rst = 1'b1;
    wait_clk();
    rst = 1'b0;
    check_eq("midclear_rst_state", state, 2'b00);
    wait_n(CC + 2);
    check_eq("midclear_stays_idle", state, 2'b00);

    // Scores 6:5 arrive on the same cycle as the final tick.
    to_play("both_to_play");
    wait_n(3 * TPS - 1);
    check_eq("both_pre_time",  time_left, 8'd1);
    check_eq("both_pre_state", state,     2'b10);
    points_1 = 5'd6;
    points_2 = 5'd5;
    wait_clk();
    check_eq("both_state",  state,     2'b11);
    check_eq("both_winner", winner,    2'b01);
    check_eq("both_time",   time_left, 8'd0);

    // Player 2 wins on score.
    points_1 = 5'd1;
    points_2 = 5'd0;
    to_play("p2_to_play");
    points_2 = 5'd7;
    wait_clk();
    check_eq("p2_state",  state,  2'b11);
    check_eq("p2_winner", winner, 2'b10);

    // Start pressed during PLAY is ignored.
    points_1 = 5'd0;
    points_2 = 5'd0;
    to_play("ign_to_play");
    wait_n(2);
    start = 1'b1;
    wait_n(2);
    start = 1'b0;
    check_eq("play_start_ignored", state,     2'b10);
    check_eq("play_start_time",    time_left, 8'd3);

    // ---------------------------------------------------------------- report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/game_round_ctrl.md
GAME_ROUND_CTRL -- requirements
Module: game_round_ctrl

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 65_000_000, clk cycles per game second.
REQ-002 SHALL have parameter ROUND_SEC, default 60, round length in seconds (1..255).
REQ-003 SHALL have parameter WIN_POINTS, default 20, score that ends the round (1..31).
REQ-004 SHALL have parameter CLEAR_CYCLES, default 4, gen_rst pulse length in cycles (>=1).
REQ-005 SHALL have port clk  input  1  system clock; single clock domain.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  start button level, already debounced and synchronous.
REQ-008 SHALL have ports points_1, points_2  input  5 each  scores from the point generator.
REQ-009 SHALL have port gen_rst  output  1  reset to the point generator and score counters.
REQ-010 SHALL have port game_active  output  1  high only in PLAY; gates player movement.
REQ-011 SHALL have port time_left  output  8  seconds remaining in the round.
REQ-012 SHALL have port winner  output  2  00 none, 01 player 1, 10 player 2, 11 draw.
REQ-013 SHALL have port state  output  2  00 IDLE, 01 CLEAR, 10 PLAY, 11 OVER.

Function
REQ-014 SHALL register all outputs (Moore style); no combinational input-to-output path.
REQ-015 SHALL register start each cycle; start_edge = start AND NOT start_q.
REQ-016 In IDLE: gen_rst=1, game_active=0, time_left=ROUND_SEC, winner=00; start_edge moves to CLEAR.
REQ-017 On entry to CLEAR: clear winner, load the clear counter, set time_left=ROUND_SEC.
REQ-018 In CLEAR: gen_rst=1 for exactly CLEAR_CYCLES cycles, then PLAY on the following edge.
REQ-019 On entry to PLAY: gen_rst=0, game_active=1, second prescaler=0.
REQ-020 In PLAY: prescaler counts 0..TICKS_PER_SEC-1 and wraps; tick when it equals TICKS_PER_SEC-1.
REQ-021 On tick in PLAY: time_left decrements by 1 and never goes below 0.
REQ-022 Each PLAY cycle, score end = points_1>=WIN_POINTS or points_2>=WIN_POINTS; time end = tick with time_left==1.
REQ-023 On score end or time end: next state OVER, game_active=0 on that same edge.
REQ-024 Winner on entering OVER: points_1>points_2 gives 01, points_2>points_1 gives 10, equal gives 11.
REQ-025 When score end and time end coincide, the REQ-024 rule applies; time_left still reaches 0.
REQ-026 In OVER: gen_rst=0 so scores stay visible; winner and time_left hold; start_edge moves to CLEAR.
REQ-027 start_edge in CLEAR or PLAY SHALL be ignored; a held start SHALL NOT retrigger.
REQ-028 Prescaler and clear counter SHALL be sized by $clog2 of their parameter; no overflow at defaults.

Reset
REQ-029 rst SHALL override every state, including mid-CLEAR and mid-PLAY.
REQ-030 After rst: state=IDLE, gen_rst=1, game_active=0, time_left=ROUND_SEC, winner=00, prescaler=0, start_q=0.
REQ-031 start held high through reset release SHALL NOT produce a start_edge.

Verification (TICKS_PER_SEC=10, ROUND_SEC=3, WIN_POINTS=5, CLEAR_CYCLES=4)
REQ-032 Reset, then one start pulse: state 01 with gen_rst=1 for exactly 4 cycles, then state 10, game_active=1, time_left=3.
REQ-033 PLAY with scores held at 2 and 2: time_left goes 2, 1, 0 every 10 cycles; on the third tick state 11, winner=11.
REQ-034 PLAY with points_1 stepped to 5 while points_2=3: state 11 on the next edge, winner=01, time_left frozen.
REQ-035 In OVER, start held high for 50 cycles: exactly one CLEAR entry, winner cleared, gen_rst pulses 4 cycles.
REQ-036 rst asserted mid-PLAY at time_left=2: next edge state 00, gen_rst=1, time_left=3, winner=00.
REQ-037 Scores 6 and 5 arriving on the same cycle as the final tick: state 11, winner=01, time_left=0.
